// File: rtl/sr_pkg.sv
// Shared definitions for the serial configuration-chain controllers:
// FSM encoding, default chain width and counter sizing.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FIN   = 2'd3
  } sr_state_e;

  localparam int unsigned SR_DEFAULT_WIDTH = 170;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int unsigned sr_cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      sr_cnt_width = 1;
    end else begin
      sr_cnt_width = $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/sr_clk_div.sv
// Half-period divider for serial config clocks: a tick every CLK_DIV enabled
// cycles, plus a phase bit and the rise/fall enables derived from it.
module sr_clk_div
  import sr_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic phase_o
);

  localparam int unsigned   HW      = sr_cnt_width(CLK_DIV);
  localparam logic [HW-1:0] HP_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] hp_q, hp_d;
  logic          ph_q, ph_d;

  // Phase 0 is the low half of the serial clock, phase 1 the high half.
  assign tick_o  = en_i & (hp_q == HP_LAST);
  assign rise_o  = tick_o & ~ph_q;
  assign fall_o  = tick_o & ph_q;
  assign phase_o = ph_q;

  // Next-state for the half-period counter and phase bit.
  always_comb begin
    hp_d = hp_q;
    ph_d = ph_q;
    if (clr_i) begin
      hp_d = '0;
      ph_d = 1'b0;
    end else if (en_i) begin
      if (tick_o) begin
        hp_d = '0;
        ph_d = ~ph_q;
      end else begin
        hp_d = hp_q + HW'(1);
        ph_d = ph_q;
      end
    end else begin
      hp_d = hp_q;
      ph_d = ph_q;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_q <= '0;
      ph_q <= 1'b0;
    end else begin
      hp_q <= hp_d;
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/sr_rw_ctrl.sv
// Mic4 configuration-chain controller: shifts a WIDTH-bit word out on
// clk_sr/din_sr, captures the old chain contents from dout_sr, optional load_sr.
module sr_rw_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH     = SR_DEFAULT_WIDTH,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             load_en,
  input  logic             dout_sr,
  output logic             clk_sr,
  output logic             din_sr,
  output logic             load_sr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned   BW       = sr_cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  sr_state_e        state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] dout_q;
  logic [BW-1:0]    bit_q;
  logic             load_en_q;
  logic             clk_sr_q;
  logic             din_sr_q;
  logic             load_sr_q;
  logic             busy_q;
  logic             done_q;

  logic div_clr_s, div_en_s, tick_s, rise_s, fall_s, phase_s;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      head_bit = w[WIDTH-1];
    end else begin
      head_bit = w[0];
    end
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      shift_out = {w[WIDTH-2:0], 1'b0};
    end else begin
      shift_out = {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // The first captured bit must end up where the first written bit came from,
  // so a chain preloaded with P reads back as P.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    if (MSB_FIRST) begin
      shift_in = {w[WIDTH-2:0], b};
    end else begin
      shift_in = {b, w[WIDTH-1:1]};
    end
  endfunction

  assign div_clr_s = (state_q == ST_IDLE);
  assign div_en_s  = (state_q == ST_SHIFT) | (state_q == ST_LOAD);

  sr_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (div_clr_s),
    .en_i    (div_en_s),
    .tick_o  (tick_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s),
    .phase_o (phase_s)
  );

  // Main FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cap_q     <= '0;
      dout_q    <= '0;
      bit_q     <= '0;
      load_en_q <= 1'b0;
      clk_sr_q  <= 1'b0;
      din_sr_q  <= 1'b0;
      load_sr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shreg_q   <= din;
            load_en_q <= load_en;
            bit_q     <= '0;
            busy_q    <= 1'b1;
            clk_sr_q  <= 1'b0;
            din_sr_q  <= head_bit(din);
            state_q   <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Sample the tail just before the chip sees the rising edge.
          if (rise_s) begin
            clk_sr_q <= 1'b1;
            cap_q    <= shift_in(cap_q, dout_sr);
          end else if (fall_s) begin
            clk_sr_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
              if (load_en_q) begin
                load_sr_q <= 1'b1;
                state_q   <= ST_LOAD;
              end else begin
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                dout_q   <= cap_q;
                din_sr_q <= 1'b0;
                state_q  <= ST_FIN;
              end
            end else begin
              bit_q    <= bit_q + BW'(1);
              shreg_q  <= shift_out(shreg_q);
              din_sr_q <= head_bit(shift_out(shreg_q));
            end
          end else begin
            clk_sr_q <= clk_sr_q;
          end
        end
        ST_LOAD: begin
          // The divider keeps running, so the end of its high phase marks 2*CLK_DIV cycles.
          if (tick_s && phase_s) begin
            load_sr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            dout_q    <= cap_q;
            din_sr_q  <= 1'b0;
            state_q   <= ST_FIN;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          clk_sr_q  <= 1'b0;
          din_sr_q  <= 1'b0;
          load_sr_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign clk_sr  = clk_sr_q;
  assign din_sr  = din_sr_q;
  assign load_sr = load_sr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_sr_rw_ctrl.sv
// Directed bench for sr_rw_ctrl: two configurations, each with a behavioural
// model of the chip chain (shift on clk_sr rise, latch on load_sr).
module tb_sr_rw_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 170 bits, CLK_DIV=4, MSB first
  logic         rst_a = 1'b1;
  logic [169:0] din_a = '0;
  logic         start_a_s = 1'b0;
  logic         load_en_a = 1'b0;
  logic         dout_sr_a;
  logic         clk_sr_a, din_sr_a, load_sr_a, busy_a, done_a;
  logic [169:0] dout_a;

  // DUT B: 8 bits, CLK_DIV=1, LSB first
  logic         rst_b = 1'b1;
  logic [7:0]   din_b = '0;
  logic         start_b = 1'b0;
  logic         load_en_b = 1'b0;
  logic         dout_sr_b;
  logic         clk_sr_b, din_sr_b, load_sr_b, busy_b, done_b;
  logic [7:0]   dout_b;

  sr_rw_ctrl #(.WIDTH(170), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .start(start_a_s), .load_en(load_en_a),
    .dout_sr(dout_sr_a), .clk_sr(clk_sr_a), .din_sr(din_sr_a), .load_sr(load_sr_a),
    .busy(busy_a), .done(done_a), .dout(dout_a)
  );

  sr_rw_ctrl #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .start(start_b), .load_en(load_en_b),
    .dout_sr(dout_sr_b), .clk_sr(clk_sr_b), .din_sr(din_sr_b), .load_sr(load_sr_b),
    .busy(busy_b), .done(done_b), .dout(dout_b)
  );

  // Chip chain models
  logic [169:0] chain_a = '0;
  logic [169:0] latch_a = '0;
  logic [7:0]   chain_b = 8'h3C;
  logic [7:0]   latch_b = 8'h00;

  assign dout_sr_a = chain_a[169];
  assign dout_sr_b = chain_b[0];

  always @(posedge clk_sr_a) chain_a <= {chain_a[168:0], din_sr_a};
  always @(posedge load_sr_a) latch_a <= chain_a;
  always @(posedge clk_sr_b) chain_b <= {din_sr_b, chain_b[7:1]};
  always @(posedge load_sr_b) latch_b <= chain_b;

  int n_total = 0;
  int n_pass  = 0;

  // Results of the last observed operation
  int   op_n, op_dn, op_tog;
  logic op_ld, op_moved;

  typedef struct {
    logic [169:0] din;
    logic         le;
    logic [169:0] exp_dout;
    logic [169:0] exp_latch;
    logic [169:0] exp_chain;
    int           exp_busy;
    logic         exp_load;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [169:0] act, input logic [169:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic start_op_a(input logic [169:0] d, input logic le);
    @(negedge clk);
    din_a = d;
    load_en_a = le;
    start_a_s = 1'b1;
    @(negedge clk);
    start_a_s = 1'b0;
  endtask

  // Count busy cycles from the current negedge; returns at the first non-busy sample.
  task automatic wait_busy_a();
    logic [169:0] d0;
    d0 = dout_a;
    op_n = 0; op_dn = 0; op_ld = 1'b0; op_moved = 1'b0;
    while (busy_a === 1'b1 && op_n < 4000) begin
      op_n++;
      if (done_a === 1'b1) op_dn++;
      if (load_sr_a === 1'b1) op_ld = 1'b1;
      if (dout_a !== d0) op_moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic tail_a();
    for (int k = 0; k < 3; k++) begin
      if (done_a === 1'b1) op_dn++;
      if (load_sr_a === 1'b1) op_ld = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [169:0] v1;
    logic [169:0] snap;
    logic         prev;
    int           dcount;

    v1 = {1'b1, 169'b1011};
    vecs[0] = '{din: v1,       le: 1'b1, exp_dout: '0,  exp_latch: v1, exp_chain: v1,       exp_busy: 1368, exp_load: 1'b1};
    vecs[1] = '{din: '1,       le: 1'b1, exp_dout: v1,  exp_latch: '1, exp_chain: '1,       exp_busy: 1368, exp_load: 1'b1};
    vecs[2] = '{din: 170'h5,   le: 1'b0, exp_dout: '1,  exp_latch: '1, exp_chain: 170'h5,   exp_busy: 1360, exp_load: 1'b0};

    // Reset state
    #100;
    chk("rst_ctl_a", {165'd0, busy_a, done_a, clk_sr_a, din_sr_a, load_sr_a}, 170'd0);
    chk("rst_dout_a", dout_a, 170'd0);
    chk("rst_ctl_b", {165'd0, busy_b, done_b, clk_sr_b, din_sr_b, load_sr_b}, 170'd0);
    chk("rst_dout_b", {162'd0, dout_b}, 170'd0);
    #100;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Table-driven operations on DUT A
    for (int i = 0; i < 3; i++) begin
      start_op_a(vecs[i].din, vecs[i].le);
      wait_busy_a();
      chk($sformatf("v%0d_busy_len", i), 170'(op_n), 170'(vecs[i].exp_busy));
      chk($sformatf("v%0d_dout_stable", i), {169'd0, op_moved}, 170'd0);
      tail_a();
      chk($sformatf("v%0d_done_pulses", i), 170'(op_dn), 170'd1);
      chk($sformatf("v%0d_load_seen", i), {169'd0, op_ld}, {169'd0, vecs[i].exp_load});
      chk($sformatf("v%0d_dout", i), dout_a, vecs[i].exp_dout);
      chk($sformatf("v%0d_latch", i), latch_a, vecs[i].exp_latch);
      chk($sformatf("v%0d_chain", i), chain_a, vecs[i].exp_chain);
    end

    // DUT B: fast clock, LSB first
    @(negedge clk);
    din_b = 8'hA5; load_en_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_first_din_sr", {169'd0, din_sr_b}, 170'd1);
    chk("b_first_clk_sr", {169'd0, clk_sr_b}, 170'd0);
    op_n = 0; op_tog = 0; op_ld = 1'b0; prev = clk_sr_b;
    while (busy_b === 1'b1 && op_n < 200) begin
      op_n++;
      if (clk_sr_b !== prev) op_tog++;
      prev = clk_sr_b;
      if (load_sr_b === 1'b1) op_ld = 1'b1;
      @(negedge clk);
    end
    chk("b_busy_len", 170'(op_n), 170'd18);
    chk("b_clk_toggles", 170'(op_tog), 170'd16);
    chk("b_done", {169'd0, done_b}, 170'd1);
    chk("b_load_seen", {169'd0, op_ld}, 170'd1);
    chk("b_chain", {162'd0, chain_b}, {162'd0, 8'hA5});
    chk("b_latch", {162'd0, latch_b}, {162'd0, 8'hA5});
    chk("b_dout", {162'd0, dout_b}, {162'd0, 8'h3C});

    // Start during busy and in FIN is ignored; start right after done is taken
    start_op_a(170'hA, 1'b0);
    repeat (99) @(negedge clk);
    din_a = '1; load_en_a = 1'b1; start_a_s = 1'b1;
    @(negedge clk);
    start_a_s = 1'b0;
    wait_busy_a();
    chk("t6_busy_len", 170'(op_n), 170'(1360 - 100));
    chk("t6_no_load", {169'd0, op_ld}, 170'd0);
    chk("t6_fin_done", {169'd0, done_a}, 170'd1);
    chk("t6_chain", chain_a, 170'hA);
    din_a = 170'h7; load_en_a = 1'b0; start_a_s = 1'b1;
    @(negedge clk);
    chk("t6_fin_start_ignored", {168'd0, busy_a, done_a}, 170'd0);
    @(negedge clk);
    start_a_s = 1'b0;
    chk("t6_after_done_accepted", {169'd0, busy_a}, 170'd1);
    wait_busy_a();
    chk("t6_op2_busy_len", 170'(op_n), 170'd1360);
    chk("t6_op2_dout", dout_a, 170'hA);
    tail_a();
    chk("t6_op2_chain", chain_a, 170'h7);

    // Reset during bit 50 aborts silently; a later operation completes normally
    start_op_a('1, 1'b1);
    repeat (405) @(negedge clk);
    chk("t5_mid_op_busy", {169'd0, busy_a}, 170'd1);
    #2 rst_a = 1'b1;
    #1;
    chk("t5_async_ctl", {165'd0, busy_a, done_a, clk_sr_a, din_sr_a, load_sr_a}, 170'd0);
    chk("t5_async_dout", dout_a, 170'd0);
    dcount = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) dcount++;
    end
    rst_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) dcount++;
    end
    chk("t5_no_done_after_abort", 170'(dcount), 170'd0);
    snap = chain_a;
    start_op_a(170'h5, 1'b1);
    wait_busy_a();
    chk("t5_busy_len", 170'(op_n), 170'd1368);
    tail_a();
    chk("t5_done_pulses", 170'(op_dn), 170'd1);
    chk("t5_dout", dout_a, snap);
    chk("t5_chain", chain_a, 170'h5);
    chk("t5_latch", latch_a, 170'h5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
